// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer, valid/ready handshake,
// flush-over-stall priority, occupancy output and saturating event counters.
//
// state | meaning
// EMPTY | no live entry; out_data = NOP_VALUE
// ONE   | head (main) live, skid empty
// FULL  | head and skid both live; in_ready low
module pipe_skid_reg #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic main_v, skid_v, in_fire, out_fire;

  // in_ready depends only on state and the stall/flush inputs, never on out_ready
  assign main_v    = (state_q != EMPTY);
  assign skid_v    = (state_q == FULL);
  assign in_ready  = ~skid_v & ~stall & ~flush;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready & ~stall & ~flush;

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      // stall is already folded into in_fire/out_fire, so it simply holds here
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_fire && (xfer_cnt_q != '1))
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    if (stall && main_v && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && main_v && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: scoreboard on the main instance plus a CNT_W=2 instance
// for counter saturation.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       Reset, stall, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] xfer_cnt, stall_cnt, flush_cnt;

  logic       s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occ;
  logic [1:0] s_xfer, s_stall_cnt, s_flush_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stream_v[3];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(16)) dut (
    .Clk(clk), .Reset(Reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(2)) u_sat (
    .Clk(clk), .Reset(Reset), .stall(1'b0), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .xfer_cnt(s_xfer), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every out-side transfer, push on every accepted input
  always @(negedge clk) begin
    if (Reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && !stall) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    Reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;

    // reset
    step(); step();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_cnts", {xfer_cnt, stall_cnt | flush_cnt}, 32'd0);

    // streaming
    stream_v[0] = 8'h11; stream_v[1] = 8'h22; stream_v[2] = 8'h33;
    out_ready = 1'b1; in_valid = 1'b1; in_data = stream_v[0];
    for (int i = 0; i < 3; i++) begin
      step();
      in_data = (i < 2) ? stream_v[i+1] : 8'h00;
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
      chk("stream_data", {24'd0, out_data}, {24'd0, stream_v[i]});
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    step();
    @(negedge clk);
    chk("stream_xfer", {16'd0, xfer_cnt}, 32'd3);
    chk("stream_empty", {30'd0, occupancy}, 32'd0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step(); in_data = 8'h0B;
    step(); in_data = 8'h0C;
    @(negedge clk);
    chk("bp_occ_full", {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_c_not_taken", {22'd0, occupancy, out_data}, {22'd0, 2'd2, 8'h0A});
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_a", {24'd0, out_data}, 32'h0A);
    step();
    @(negedge clk);
    chk("bp_head_b", {24'd0, out_data}, 32'h0B);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("bp_drained", {30'd0, occupancy}, 32'd0);
    chk("bp_xfer", {16'd0, xfer_cnt}, 32'd5);

    // stall while full, then flush over stall
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step(); in_data = 8'h0B;
    step(); in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", {24'd0, out_data}, 32'h0A);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    flush = 1'b1;
    @(negedge clk);
    chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    chk("stall_xfer_held", {16'd0, xfer_cnt}, 32'd5);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_out_data", {24'd0, out_data}, 32'h00);
    chk("flush_cnt1", {16'd0, flush_cnt}, 32'd1);
    chk("flush_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_no_inc", {16'd0, flush_cnt}, 32'd1);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // reset mid-transfer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    step(); Reset = 1'b1; in_data = 8'h66;
    step(); Reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_occ", {30'd0, occupancy}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'h00);
    chk("midrst_xfer", {16'd0, xfer_cnt}, 32'd0);

    // saturation on the CNT_W=2 instance
    s_out_ready = 1'b1; s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_data = 8'(8'h40 + i);
      step();
      @(negedge clk);
      chk("sat_data", {24'd0, s_out_data}, {24'd0, 8'(8'h40 + i)});
    end
    s_in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("sat_xfer", {30'd0, s_xfer}, 32'd3);
    step();
    @(negedge clk);
    chk("sat_xfer_held", {30'd0, s_xfer}, 32'd3);

    chk("sb_empty_at_end", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
